// File: rtl/exu_pipe_ctrl.sv
// Execute-stage pipeline controller: dispatches ALU, memory and multiply/divide
// instructions, tracks their completion and hands results downstream.

`ifndef INST_LOAD
`define INST_LOAD 1
`endif
`ifndef INST_STORE
`define INST_STORE 2
`endif
`ifndef INST_MULDIV
`define INST_MULDIV 3
`endif

module exu_pipe_ctrl #(
    parameter int TYPE_W  = 8,
    parameter int MDU_LAT = 4,
    parameter int TIMEOUT = 64,
    parameter int BYPASS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    input  logic [TYPE_W-1:0] inst_type_i,
    input  logic              flush_i,
    output logic              access_begin_o,
    input  logic              access_done_i,
    output logic              mdu_start_o,
    output logic              we_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int LAT_W = $clog2(MDU_LAT + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MEM_REQ    = 3'd1,
        MEM_WAIT   = 3'd2,
        MULTI      = 3'd3,
        WAIT_READY = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           disp_state;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             kill_q;
    logic             kill_nxt;
    logic             kill_eff;
    logic             mdu_nxt;
    logic             accept;
    logic             is_mem;
    logic             is_mul;

    assign is_mem = (inst_type_i == TYPE_W'(`INST_LOAD)) ||
                    (inst_type_i == TYPE_W'(`INST_STORE));
    assign is_mul = (inst_type_i == TYPE_W'(`INST_MULDIV));

    assign ready_pre_o = !flush_i &&
                         ((state == IDLE) ||
                          ((BYPASS != 0) && (state == WAIT_READY) && ready_post_i));
    assign accept      = valid_pre_i && ready_pre_o;
    assign we_o        = accept;
    assign err_o       = err_q;

    // A flush during a memory access cannot cancel the bus transfer, so it is
    // remembered and the completion is simply discarded.
    assign kill_eff = kill_q || flush_i;

    always_comb begin
        disp_state = WAIT_READY;
        if (is_mem) begin
            disp_state = MEM_REQ;
        end else if (is_mul) begin
            disp_state = MULTI;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        to_nxt    = to_cnt;
        err_nxt   = err_q;
        kill_nxt  = kill_q;
        mdu_nxt   = 1'b0;

        case (state)
            IDLE: begin
                err_nxt  = 1'b0;
                kill_nxt = 1'b0;
            end
            MEM_REQ: begin
                to_nxt   = '0;
                kill_nxt = kill_eff;
                if (access_done_i) begin
                    state_nxt = kill_eff ? IDLE : WAIT_READY;
                    if (kill_eff) begin
                        kill_nxt = 1'b0;
                    end
                end else begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                to_nxt   = to_cnt + TO_W'(1);
                kill_nxt = kill_eff;
                if (access_done_i || (to_cnt == TO_W'(TIMEOUT - 1))) begin
                    if (kill_eff) begin
                        state_nxt = IDLE;
                        kill_nxt  = 1'b0;
                    end else begin
                        state_nxt = WAIT_READY;
                        err_nxt   = !access_done_i;
                    end
                end
            end
            MULTI: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (lat_cnt == '0) begin
                    state_nxt = WAIT_READY;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            WAIT_READY: begin
                if (flush_i || ready_post_i) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                lat_nxt   = '0;
                to_nxt    = '0;
                err_nxt   = 1'b0;
                kill_nxt  = 1'b0;
            end
        endcase

        // Accept is only possible in IDLE or on a bypass handshake, so it
        // overrides whatever the current state decided.
        if (accept) begin
            state_nxt = disp_state;
            err_nxt   = 1'b0;
            kill_nxt  = 1'b0;
            to_nxt    = '0;
            if (is_mul) begin
                lat_nxt = LAT_W'(MDU_LAT - 1);
                mdu_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            to_cnt         <= '0;
            err_q          <= 1'b0;
            kill_q         <= 1'b0;
            access_begin_o <= 1'b0;
            mdu_start_o    <= 1'b0;
            valid_post_o   <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_nxt;
            lat_cnt        <= lat_nxt;
            to_cnt         <= to_nxt;
            err_q          <= err_nxt;
            kill_q         <= kill_nxt;
            access_begin_o <= (state_nxt == MEM_REQ);
            mdu_start_o    <= mdu_nxt;
            valid_post_o   <= (state_nxt == WAIT_READY);
            busy_o         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_exu_pipe_ctrl.sv
// Bench for exu_pipe_ctrl: reset checks, a directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.

`ifndef INST_LOAD
`define INST_LOAD 1
`endif
`ifndef INST_STORE
`define INST_STORE 2
`endif
`ifndef INST_MULDIV
`define INST_MULDIV 3
`endif

module tb_exu_pipe_ctrl;

    localparam int LAT = 4;
    localparam int TO  = 8;
    localparam logic [7:0] T_LOAD  = 8'(`INST_LOAD);
    localparam logic [7:0] T_STORE = 8'(`INST_STORE);
    localparam logic [7:0] T_MUL   = 8'(`INST_MULDIV);
    localparam logic [7:0] T_ALU   = 8'h10;
    localparam int K_ALU = 0;
    localparam int K_MEM = 1;
    localparam int K_MUL = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid_pre = 1'b0;
    logic       ready_post = 1'b0;
    logic [7:0] inst_type = '0;
    logic       flush = 1'b0;
    logic       access_done = 1'b0;

    logic ready_pre, valid_post, access_begin, mdu_start, we, err, busy;
    logic ready_pre_b, valid_post_b, access_begin_b, mdu_start_b, we_b, err_b, busy_b;

    logic [6:0] obs;
    assign obs = {valid_post, busy, access_begin, mdu_start, err, ready_pre, we};

    exu_pipe_ctrl #(.TYPE_W(8), .MDU_LAT(LAT), .TIMEOUT(TO), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .valid_pre_i(valid_pre), .ready_pre_o(ready_pre),
        .valid_post_o(valid_post), .ready_post_i(ready_post),
        .inst_type_i(inst_type), .flush_i(flush),
        .access_begin_o(access_begin), .access_done_i(access_done),
        .mdu_start_o(mdu_start), .we_o(we), .err_o(err), .busy_o(busy)
    );

    exu_pipe_ctrl #(.TYPE_W(8), .MDU_LAT(LAT), .TIMEOUT(TO), .BYPASS(0)) dut_nobyp (
        .clock(clock), .reset(reset),
        .valid_pre_i(valid_pre), .ready_pre_o(ready_pre_b),
        .valid_post_o(valid_post_b), .ready_post_i(ready_post),
        .inst_type_i(inst_type), .flush_i(flush),
        .access_begin_o(access_begin_b), .access_done_i(access_done),
        .mdu_start_o(mdu_start_b), .we_o(we_b), .err_o(err_b), .busy_o(busy_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       v;
        logic [7:0] t;
        logic       rp;
        logic       fl;
        logic       dn;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[17];

    // Transaction-level reference: one instruction in flight, aged in cycles.
    bit m_busy, m_res, m_err, m_killed;
    int m_kind, m_age;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] t, input logic rp,
                                 input logic fl, input logic dn);
        valid_pre   = v;
        inst_type   = t;
        ready_post  = rp;
        flush       = fl;
        access_done = dn;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] t, input logic rp,
                                input logic fl, input logic dn, input logic [6:0] exp);
        vec_t r;
        r.v = v; r.t = t; r.rp = rp; r.fl = fl; r.dn = dn; r.exp = exp;
        return r;
    endfunction

    function automatic int kind_of(input logic [7:0] t);
        if (t == T_LOAD || t == T_STORE) return K_MEM;
        if (t == T_MUL) return K_MUL;
        return K_ALU;
    endfunction

    function automatic logic [6:0] model_out(input logic v, input logic rp, input logic fl);
        logic rpre;
        rpre = !fl && (!m_busy || (m_res && rp));
        return {m_res, m_busy,
                m_busy && !m_res && m_kind == K_MEM && m_age == 1,
                m_busy && !m_res && m_kind == K_MUL && m_age == 1,
                m_res && m_err, rpre, v && rpre};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_res = 0; m_err = 0; m_killed = 0; m_kind = K_ALU; m_age = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] t, input logic rp,
                              input logic fl, input logic dn);
        bit acc;
        acc = v && !fl && (!m_busy || (m_res && rp));
        if (fl && (!m_busy || m_res || m_kind != K_MEM)) begin
            m_busy = 0; m_res = 0; m_err = 0;
        end else if (m_busy && !m_res) begin
            if (m_kind == K_MEM) begin
                m_killed = m_killed | fl;
                if (dn || m_age == TO + 1) begin
                    if (m_killed) m_busy = 0;
                    else begin m_res = 1; m_err = !dn; end
                end else begin
                    m_age++;
                end
            end else if (m_age == LAT) begin
                m_res = 1;
            end else begin
                m_age++;
            end
        end else if (m_res && rp) begin
            m_busy = 0; m_res = 0; m_err = 0;
        end
        if (acc) begin
            m_busy = 1; m_kind = kind_of(t); m_res = (m_kind == K_ALU);
            m_age = 1; m_killed = 0; m_err = 0;
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(0, '0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt, seen, acc_a, acc_b, vp_a;

        tbl[0]  = mk(1, T_ALU,  1, 0, 0, 7'b0000011);
        tbl[1]  = mk(1, T_ALU,  1, 0, 0, 7'b1100011);
        tbl[2]  = mk(1, T_LOAD, 1, 0, 0, 7'b1100011);
        tbl[3]  = mk(0, T_ALU,  1, 0, 0, 7'b0110000);
        tbl[4]  = mk(1, T_ALU,  1, 0, 0, 7'b0100000);
        tbl[5]  = mk(0, T_ALU,  1, 0, 0, 7'b0100000);
        tbl[6]  = mk(0, T_ALU,  1, 0, 1, 7'b0100000);
        tbl[7]  = mk(0, T_ALU,  0, 0, 0, 7'b1100000);
        tbl[8]  = mk(1, T_MUL,  1, 0, 0, 7'b1100011);
        tbl[9]  = mk(0, T_ALU,  1, 0, 0, 7'b0101000);
        tbl[10] = mk(0, T_ALU,  1, 0, 0, 7'b0100000);
        tbl[11] = mk(0, T_ALU,  1, 0, 0, 7'b0100000);
        tbl[12] = mk(0, T_ALU,  1, 0, 0, 7'b0100000);
        tbl[13] = mk(0, T_ALU,  1, 0, 0, 7'b1100010);
        tbl[14] = mk(0, T_ALU,  1, 0, 0, 7'b0000010);
        tbl[15] = mk(1, T_ALU,  1, 1, 0, 7'b0000000);
        tbl[16] = mk(0, T_ALU,  1, 0, 0, 7'b0000010);

        // Outputs while reset is held low
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("reset_idle", obs, 7'b0000010);
        applyStimulus(1, T_ALU, 0, 1, 0);
        checkOutput("reset_flush_gate", obs, 7'b0000000);
        applyStimulus(1, T_ALU, 0, 0, 0);
        checkOutput("reset_ready", obs, 7'b0000011);
        applyStimulus(0, '0, 0, 0, 0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].v, tbl[i].t, tbl[i].rp, tbl[i].fl, tbl[i].dn);
            checkOutput($sformatf("vec%0d", i), obs, tbl[i].exp);
            tick();
        end

        // Store with no completion: timeout error after TO+1 cycles
        applyStimulus(1, T_STORE, 0, 0, 0);
        checkOutput("st_we", we, 1);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("st_begin", access_begin, 1);
        cnt = 0; seen = 0;
        while (!valid_post && cnt < 40) begin
            tick();
            cnt++;
            seen += access_begin;
        end
        checkOutput("st_timeout_lat", cnt, TO + 1);
        checkOutput("st_single_begin", seen, 0);
        checkOutput("st_err", err, 1);
        applyStimulus(0, '0, 1, 0, 0);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("st_err_clear", {valid_post, err}, 2'b00);

        // Multiply flushed in its second cycle
        applyStimulus(1, T_MUL, 0, 0, 0);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("mul_start", mdu_start, 1);
        tick();
        checkOutput("mul_start_once", mdu_start, 0);
        applyStimulus(0, '0, 0, 1, 0);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("mul_flush_idle", {valid_post, busy}, 2'b00);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen += valid_post;
        end
        checkOutput("mul_flush_no_valid", seen, 0);

        // Load flushed while waiting for memory
        seen = 0;
        applyStimulus(1, T_LOAD, 1, 0, 0);
        tick();
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("ld_begin", access_begin, 1);
        tick();
        applyStimulus(0, '0, 1, 1, 0);
        checkOutput("ld_flush_busy", busy, 1);
        tick();
        seen += valid_post;
        applyStimulus(0, '0, 1, 0, 0);
        tick();
        seen += valid_post;
        applyStimulus(0, '0, 1, 0, 1);
        tick();
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("ld_kill_idle", {busy, err}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            seen += valid_post;
            tick();
        end
        checkOutput("ld_kill_no_valid", seen, 0);

        // Asynchronous reset in the middle of a multiply
        applyStimulus(1, T_MUL, 0, 0, 0);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        tick();
        checkOutput("rst_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", obs, 7'b0000010);
        tick();
        reset = 1'b1;
        applyStimulus(1, T_ALU, 0, 0, 0);
        checkOutput("first_dispatch_we", we, 1);
        tick();
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("first_dispatch_valid", valid_post, 1);

        // Back-to-back ALU ops with and without bypass
        doReset();
        acc_a = 0; acc_b = 0; vp_a = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, T_ALU, 1, 0, 0);
            acc_a += we;
            acc_b += we_b;
            if (i >= 1) vp_a += valid_post;
            if (i == 1) checkOutput("nobyp_ready_low", {valid_post_b, ready_pre_b}, 2'b10);
            tick();
        end
        checkOutput("byp_accepts", acc_a, 8);
        checkOutput("byp_valid", vp_a, 7);
        checkOutput("nobyp_accepts", acc_b, 4);

        // Randomized run against the reference model
        doReset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            logic v, rp, fl, dn;
            logic [7:0] t;
            v  = ($urandom_range(9) < 7);
            rp = ($urandom_range(9) < 6);
            fl = ($urandom_range(19) == 0);
            dn = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       t = T_LOAD;
                1:       t = T_STORE;
                2:       t = T_MUL;
                default: t = 8'($urandom_range(255));
            endcase
            applyStimulus(v, t, rp, fl, dn);
            checkOutput($sformatf("random%0d", i), obs, model_out(v, rp, fl));
            model_step(v, t, rp, fl, dn);
            tick();
        end

        applyStimulus(0, '0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exu_pipe_ctrl.md
EXU_PIPE_CTRL -- requirements
Module: exu_pipe_ctrl

Interface
REQ-001 Parameters SHALL be:
- TYPE_W, default 8, width of inst_type_i.
- MDU_LAT, default 4, fixed multiply/divide latency in cycles; legal range >=1.
- TIMEOUT, default 64, maximum cycles to wait for access_done_i; legal range >=2.
- BYPASS, default 1; when 1, a new instruction may be accepted in the same cycle the current result is consumed.

REQ-002 Ports SHALL be:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_pre_i  in  1  upstream instruction valid.
- ready_pre_o  out  1  stage can accept an instruction.
- valid_post_o  out  1  result valid to downstream.
- ready_post_i  in  1  downstream accepts the result.
- inst_type_i  in  TYPE_W  instruction class, using `INST_LOAD, `INST_STORE and `INST_MULDIV from defines.v.
- flush_i  in  1  pipeline flush; kills the in-flight instruction.
- access_begin_o  out  1  one-cycle memory request pulse.
- access_done_i  in  1  memory access complete.
- mdu_start_o  out  1  one-cycle multiply/divide start pulse.
- we_o  out  1  capture strobe for the upstream payload registers.
- err_o  out  1  memory timeout flag, qualified by valid_post_o.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-003 The state machine SHALL have exactly these states: IDLE, MEM_REQ, MEM_WAIT, MULTI, WAIT_READY.

REQ-004 Dispatch (applies in IDLE, or in WAIT_READY when a BYPASS accept occurs) on valid_pre_i && ready_pre_o:
- `INST_LOAD or `INST_STORE -> MEM_REQ.
- `INST_MULDIV -> MULTI, with the latency counter loaded to MDU_LAT-1.
- any other class -> WAIT_READY.

REQ-005 Accept and capture rules:
- ready_pre_o = !flush_i && (IDLE || (BYPASS && WAIT_READY && ready_post_i)).
- we_o = valid_pre_i && ready_pre_o, purely combinational.

REQ-006 MEM_REQ:
- access_begin_o is asserted for exactly one cycle.
- Next state is WAIT_READY if access_done_i is high in that cycle, otherwise MEM_WAIT.
- The timeout counter clears to 0.

REQ-007 MEM_WAIT:
- The timeout counter increments every cycle.
- access_done_i -> WAIT_READY.
- Otherwise, counter == TIMEOUT-1 -> WAIT_READY with err_o set.
- If access_done_i and the timeout coincide, the cycle is treated as done and err_o stays 0.

REQ-008 MULTI:
- mdu_start_o pulses in the first MULTI cycle only.
- The latency counter decrements each cycle; at 0 the next state is WAIT_READY.
- Total latency from accept to valid_post_o is MDU_LAT+1 cycles.

REQ-009 WAIT_READY:
- valid_post_o = 1.
- On ready_post_i -> IDLE, or re-dispatch per REQ-004 when a BYPASS accept occurs in the same cycle.
- err_o clears on leaving WAIT_READY.

REQ-010 Flush in IDLE, MULTI or WAIT_READY:
- Next state is IDLE; no valid_post_o in the following cycle.
- flush_i has priority over every other transition.

REQ-011 Flush in MEM_REQ or MEM_WAIT:
- The memory access is not aborted; a registered kill flag is set instead.
- On access_done_i or timeout, the controller goes to IDLE (not WAIT_READY).
- err_o is not raised and valid_post_o is never asserted for the killed instruction.
- The kill flag clears on entering IDLE.

REQ-012 Counter widths SHALL be:
- Latency counter: $clog2(MDU_LAT+1) bits.
- Timeout counter: $clog2(TIMEOUT+1) bits.
- Neither counter wraps: each is reloaded or cleared on entering its state.

REQ-013 All outputs other than we_o and ready_pre_o SHALL be decoded from registered state only, with no combinational path from inputs.

REQ-014 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-015 While reset is low:
- State is IDLE; both counters, err_o and the kill flag are 0.
- access_begin_o, mdu_start_o, valid_post_o and busy_o are 0.
- ready_pre_o = 1, gated by !flush_i.

REQ-016 Reset asserted mid-operation SHALL force IDLE immediately and asynchronously; any in-flight instruction is dropped.

REQ-017 First dispatch SHALL be possible on the first rising clock edge after reset deasserts.

Verification
REQ-018 ALU op, ready_post_i held 1, BYPASS=1, back-to-back valid_pre_i -> valid_post_o every cycle from cycle 1; we_o high every cycle.

REQ-019 ALU op with BYPASS=0 -> ready_pre_o low in WAIT_READY; one accept per 2 cycles.

REQ-020 Load, access_done_i 3 cycles after access_begin_o -> one access_begin_o pulse, valid_post_o on the cycle after done, err_o=0.

REQ-021 Store, TIMEOUT=8, access_done_i never asserted -> valid_post_o with err_o=1 exactly 9 cycles after access_begin_o; err_o clears after the handshake.

REQ-022 MULDIV, MDU_LAT=4 -> mdu_start_o single pulse, valid_post_o 5 cycles after accept; flush_i in the 2nd MULTI cycle -> IDLE next cycle, no valid_post_o.

REQ-023 Load, flush_i in MEM_WAIT, then access_done_i -> returns to IDLE, valid_post_o never asserted; reset low in MULTI -> busy_o=0 immediately.
